seq_control_unit: RTL and testbench
===================================

# seq_control_unit

Multi-cycle, parametrised successor to the CPU's single-cycle control decoder. It fetches an opcode over a valid/ready handshake and sequences it through FETCH/DECODE/EXEC/WB. It holds its own flag register and evaluates an extended branch-condition set, and it supports HALT/resume and a retired-instruction counter. It sits between the instruction memory port and the datapath (ALU, register file, PC).

## Interface
- `OPCODE_W`, default 4: opcode width, minimum 4.
  - `opcode[OPCODE_W-1:OPCODE_W-2]` is the class.
  - The low `OPCODE_W-2` bits are the subcode.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `instr_valid` in 1: `instr_opcode` is valid.
- `instr_opcode` in `OPCODE_W`: opcode offered by the fetch port.
- `instr_ready` out 1: the block accepts an opcode this cycle.
- `cf`, `sf`, `zf` in 1 each: ALU carry, sign and zero flags, valid in EXEC.
- `resume` in 1: leave HALT.
- `op` out `OPCODE_W-2`: ALU operation, equal to the latched subcode.
- `imm_sel` out 1: select the immediate operand.
- `alu_en` out 1: ALU strobe.
- `reg_en` out 1: register-file write enable.
- `pc_inc` out 1: advance the PC by one.
- `jmp_sel` out 1: load the PC with the branch target.
- `halted` out 1: the block is in HALT.
- `retired` out `CNT_W`: count of retired instructions.

## Operation
- Instruction classes:
  - `00` ALU register.
  - `01` ALU immediate.
  - `10` branch.
  - `11` misc.
- State machine, 2-bit encoding: FETCH, DECODE, EXEC, WB, plus HALT (3-bit encoding allowed).
- FETCH:
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`, the IR latches `instr_opcode` and the FSM moves to DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: always moves to EXEC. No outputs asserted.
- EXEC, ALU classes (`00`/`01`):
  - `alu_en`=1, `op`=subcode, `imm_sel`=(class==`01`).
  - The flag register latches {`cf`,`sf`,`zf`} at the end of the cycle.
  - Next state WB.
- EXEC, branch class. Condition uses the latched flags, never the live inputs. Low two subcode bits:
  - `00` JMP: always taken.
  - `01` JGE: taken if `zf` | ~`sf`.
  - `10` JZ: taken if `zf`.
  - `11` JC: taken if `cf`.
  - Taken: `jmp_sel`=1 and `pc_inc`=0. Not taken: `pc_inc`=1.
  - Next state FETCH. The instruction retires.
- EXEC, misc class:
  - Subcode all ones is HALT: next state HALT, `pc_inc`=0, the instruction retires.
  - Any other subcode is NOP: `pc_inc`=1, retire, next state FETCH.
- WB: `reg_en`=1, `pc_inc`=1, retire, next state FETCH.
- HALT:
  - `halted`=1. `instr_ready`=0.
  - On `resume`, assert `pc_inc`=1 for that cycle, then move to FETCH.
- Retire: `retired` increments by 1 and wraps modulo 2^`CNT_W` with no saturation or flag.
- `op` and `imm_sel` are valid only while `alu_en`=1. At all other times they are driven 0.

## Timing
- Reset values, applied asynchronously while `rst_n`=0:
  - state=FETCH, IR=0, flags=0, `retired`=0.
  - `alu_en`, `reg_en`, `pc_inc`, `jmp_sel`, `halted`, `op`, `imm_sel` all 0.
  - `instr_ready`=1; handshakes during reset are ignored.
- Outputs are decoded from registered state and IR only. There is no combinational path from any input to any output.
- Latency from accept to retirement:
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch, NOP, HALT: 3 cycles.
- Throughput: at most one instruction in flight. The next accept is the cycle after retirement.
- Reset mid-instruction aborts it: no retire, flags cleared, back to FETCH.
- `instr_valid` outside FETCH is ignored. The source must hold its opcode until the handshake completes.
- `resume` outside HALT is ignored.
- `resume` in the same cycle HALT is entered (the EXEC cycle) has no effect.
- Flags are overwritten only by ALU-class EXEC. Branches, NOP and HALT preserve them.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - state enum.
  - class constants `CLS_ALU`, `CLS_IMM`, `CLS_BR`, `CLS_MISC`.
  - branch condition codes `BR_JMP`, `BR_JGE`, `BR_JZ`, `BR_JC`.
- Sub-module `branch_eval`: purely combinational. Inputs are the condition code and latched flags; output is `taken`.
- The FSM, IR, flag register and counter stay in the top module.

## Test plan
- ALU reg `0010` accepted at cycle 0: `alu_en`=1 with `op`=`10` and `imm_sel`=0 at cycle 2; `reg_en`=1 and `pc_inc`=1 at cycle 3; `retired`=1 at cycle 4.
- `0101` with flags {`cf`=0,`sf`=1,`zf`=0}, then JGE `1001`: not taken, `pc_inc`=1, `jmp_sel`=0. Repeat with `zf`=1: `jmp_sel`=1, `pc_inc`=0.
- JC `1011` after an ALU op with `cf`=1, then a NOP `1100` in between: JC is still taken because NOP preserves flags.
- HALT `1111`: `halted`=1 and `instr_ready`=0 with `instr_valid` held high for 10 cycles. `resume` pulse: `pc_inc`=1 for one cycle, then FETCH.
- `CNT_W`=4: retire 17 NOPs, `retired`=1 at the end.
- `rst_n` low during WB: `reg_en` drops immediately, `retired` and flags read 0, state FETCH.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the sequenced control unit: FSM states, opcode
// class constants and branch condition codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4,
        ST_RESUME = 3'd5
    } state_e;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_IMM  = 2'b01;
    localparam logic [1:0] CLS_BR   = 2'b10;
    localparam logic [1:0] CLS_MISC = 2'b11;

    localparam logic [1:0] BR_JMP = 2'b00;
    localparam logic [1:0] BR_JGE = 2'b01;
    localparam logic [1:0] BR_JZ  = 2'b10;
    localparam logic [1:0] BR_JC  = 2'b11;

    typedef struct packed {
        logic cf;
        logic sf;
        logic zf;
    } flags_t;

endpackage

// File: rtl/branch_eval.sv
// Combinational branch-condition evaluator working on the latched flags.
module branch_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] i_cond,
    input  logic       i_cf,
    input  logic       i_sf,
    input  logic       i_zf,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            BR_JMP:  o_taken = 1'b1;
            BR_JGE:  o_taken = i_zf | ~i_sf;
            BR_JZ:   o_taken = i_zf;
            BR_JC:   o_taken = i_cf;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control sequencer: fetch handshake, FETCH/DECODE/EXEC/WB walk,
// latched ALU flags, branch resolution, HALT/resume and a retire counter.
module seq_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] instr_opcode,
    output logic                instr_ready,
    input  logic                cf,
    input  logic                sf,
    input  logic                zf,
    input  logic                resume,
    output logic [OPCODE_W-3:0] op,
    output logic                imm_sel,
    output logic                alu_en,
    output logic                reg_en,
    output logic                pc_inc,
    output logic                jmp_sel,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    localparam int SUB_W = OPCODE_W - 2;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [OPCODE_W-1:0] r_ir;
    flags_t              r_flags;
    logic [CNT_W-1:0]    r_retired;
    logic [1:0]          w_cls;
    logic [SUB_W-1:0]    w_sub;
    logic                w_taken;
    logic                w_retire;
    logic                w_flags_ld;

    assign w_cls   = r_ir[OPCODE_W-1 -: 2];
    assign w_sub   = r_ir[SUB_W-1:0];
    assign retired = r_retired;

    branch_eval u_branch_eval (
        .i_cond  (w_sub[1:0]),
        .i_cf    (r_flags.cf),
        .i_sf    (r_flags.sf),
        .i_zf    (r_flags.zf),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_flags   <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_FETCH && instr_valid)
                r_ir <= instr_opcode;
            if (w_flags_ld)
                r_flags <= flags_t'({cf, sf, zf});
            if (w_retire)
                r_retired <= r_retired + 1'b1;
        end
    end

    // Outputs depend only on r_state/r_ir/r_flags; inputs steer next state only.
    // Resume goes through a one-cycle RESUME state so pc_inc stays registered.
    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        op          = '0;
        imm_sel     = 1'b0;
        alu_en      = 1'b0;
        reg_en      = 1'b0;
        pc_inc      = 1'b0;
        jmp_sel     = 1'b0;
        halted      = 1'b0;
        w_retire    = 1'b0;
        w_flags_ld  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    w_state_nxt = ST_DECODE;
            end
            ST_DECODE: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                case (w_cls)
                    CLS_ALU, CLS_IMM: begin
                        alu_en      = 1'b1;
                        op          = w_sub;
                        imm_sel     = (w_cls == CLS_IMM);
                        w_flags_ld  = 1'b1;
                        w_state_nxt = ST_WB;
                    end
                    CLS_BR: begin
                        jmp_sel     = w_taken;
                        pc_inc      = ~w_taken;
                        w_retire    = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                    default: begin
                        w_retire = 1'b1;
                        if (&w_sub) begin
                            w_state_nxt = ST_HALT;
                        end else begin
                            pc_inc      = 1'b1;
                            w_state_nxt = ST_FETCH;
                        end
                    end
                endcase
            end
            ST_WB: begin
                reg_en      = 1'b1;
                pc_inc      = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (resume)
                    w_state_nxt = ST_RESUME;
            end
            ST_RESUME: begin
                pc_inc      = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: per-instruction schedule model plus directed
// literal checks and a randomized run; a second instance uses CNT_W=4.
module tb_seq_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       instr_valid = 1'b0;
    logic [3:0] instr_opcode = 4'd0;
    logic       cf = 1'b0, sf = 1'b0, zf = 1'b0, resume = 1'b0;

    logic        instr_ready, imm_sel, alu_en, reg_en, pc_inc, jmp_sel, halted;
    logic [1:0]  op;
    logic [15:0] retired;
    logic        b_ready, b_imm, b_alu, b_reg, b_pc, b_jmp, b_halt;
    logic [1:0]  b_op;
    logic [3:0]  b_retired;

    always #5 clk = ~clk;

    seq_control_unit #(.OPCODE_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_opcode(instr_opcode),
        .instr_ready(instr_ready), .cf(cf), .sf(sf), .zf(zf), .resume(resume),
        .op(op), .imm_sel(imm_sel), .alu_en(alu_en), .reg_en(reg_en), .pc_inc(pc_inc),
        .jmp_sel(jmp_sel), .halted(halted), .retired(retired)
    );

    seq_control_unit #(.OPCODE_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_opcode(instr_opcode),
        .instr_ready(b_ready), .cf(cf), .sf(sf), .zf(zf), .resume(resume),
        .op(b_op), .imm_sel(b_imm), .alu_en(b_alu), .reg_en(b_reg), .pc_inc(b_pc),
        .jmp_sel(b_jmp), .halted(b_halt), .retired(b_retired)
    );

    // One expected-output record per cycle of an instruction in flight.
    typedef struct packed {
        bit       rdy, alu, imm, rg, pc, jmp, hlt;
        bit       ret, cap, toh;
        bit [1:0] op;
    } ev_t;

    ev_t         sched[$];
    bit          m_halt;
    bit [2:0]    m_fl;      // {cf,sf,zf}
    int unsigned m_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic bit br_taken(input bit [1:0] c, input bit [2:0] f);
        case (c)
            2'd0:    return 1'b1;
            2'd1:    return f[0] | ~f[1];
            2'd2:    return f[0];
            default: return f[2];
        endcase
    endfunction

    function automatic ev_t cur_exp();
        ev_t e;
        if (sched.size() > 0) return sched[0];
        e = '0;
        if (m_halt) e.hlt = 1'b1; else e.rdy = 1'b1;
        return e;
    endfunction

    task automatic plan(input bit [3:0] opc);
        ev_t e;
        bit  t;
        e = '0;
        sched.push_back(e);
        if (opc[3] == 1'b0) begin
            e = '0; e.alu = 1'b1; e.op = opc[1:0]; e.imm = opc[2]; e.cap = 1'b1;
            sched.push_back(e);
            e = '0; e.rg = 1'b1; e.pc = 1'b1; e.ret = 1'b1;
            sched.push_back(e);
        end else if (opc[2] == 1'b0) begin
            t = br_taken(opc[1:0], m_fl);
            e = '0; e.jmp = t; e.pc = ~t; e.ret = 1'b1;
            sched.push_back(e);
        end else begin
            e = '0; e.ret = 1'b1;
            if (opc[1:0] == 2'b11) e.toh = 1'b1; else e.pc = 1'b1;
            sched.push_back(e);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        ev_t e;
        e = cur_exp();
        chk("instr_ready", instr_ready, e.rdy);
        chk("alu_en", alu_en, e.alu);
        chk("op", op, e.op);
        chk("imm_sel", imm_sel, e.imm);
        chk("reg_en", reg_en, e.rg);
        chk("pc_inc", pc_inc, e.pc);
        chk("jmp_sel", jmp_sel, e.jmp);
        chk("halted", halted, e.hlt);
        chk("retired", retired, m_cnt[15:0]);
        chk("retired_w4", b_retired, m_cnt[3:0]);
    endtask

    // Called at a falling edge: drive, compare, advance model, go to next falling edge.
    task automatic cycle(input bit v, input bit [3:0] opc, input bit c, input bit s,
                         input bit z, input bit rs);
        ev_t e;
        ev_t r;
        instr_valid = v; instr_opcode = opc; cf = c; sf = s; zf = z; resume = rs;
        compare_all();
        if (sched.size() > 0) begin
            e = sched.pop_front();
            if (e.cap) m_fl = {c, s, z};
            if (e.ret) m_cnt++;
            if (e.toh) m_halt = 1'b1;
        end else if (m_halt) begin
            if (rs) begin
                m_halt = 1'b0;
                r = '0; r.pc = 1'b1;
                sched.push_back(r);
            end
        end else if (v) begin
            plan(opc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        instr_valid = 1'b1; instr_opcode = 4'b0010; resume = 1'b1;
        sched.delete(); m_halt = 1'b0; m_fl = 3'b000; m_cnt = 0;
        #1;
        compare_all();
        @(negedge clk);
        compare_all();
        instr_valid = 1'b0; resume = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input bit [3:0] opc, input bit c, input bit s, input bit z);
        cycle(1'b1, opc, c, s, z, 1'b0);
        repeat (opc[3] ? 2 : 3) cycle(1'b0, opc, c, s, z, 1'b0);
    endtask

    bit       pend_v;
    bit [3:0] pend_op;
    bit       acc;

    initial begin
        #1;
        do_reset();

        // ALU reg 0010 accepted at cycle 0
        cycle(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_alu_en", alu_en, 1);
        chk("tp_alu_op", op, 2'b10);
        chk("tp_alu_imm", imm_sel, 0);
        cycle(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_wb_reg_en", reg_en, 1);
        chk("tp_wb_pc_inc", pc_inc, 1);
        cycle(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_retired_1", retired, 1);

        // JGE after sf=1,zf=0: not taken even though live flags would take it
        run_instr(4'b0101, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'b1001, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'b1001, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("tp_jge_nt_jmp", jmp_sel, 0);
        chk("tp_jge_nt_pc", pc_inc, 1);
        cycle(1'b0, 4'b1001, 1'b1, 1'b0, 1'b1, 1'b0);

        // JGE after zf=1: taken
        run_instr(4'b0101, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("tp_jge_t_jmp", jmp_sel, 1);
        chk("tp_jge_t_pc", pc_inc, 0);
        cycle(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);

        // ALU sets cf, NOP in between, JC still taken
        run_instr(4'b0000, 1'b1, 1'b0, 1'b0);
        run_instr(4'b1100, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_jc_after_nop", jmp_sel, 1);
        cycle(1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);

        // HALT with resume asserted in its EXEC cycle: still halts
        cycle(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("tp_halted", halted, 1);
            chk("tp_halt_ready", instr_ready, 0);
            cycle(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("tp_resume_pc_inc", pc_inc, 1);
        cycle(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_resume_fetch", instr_ready, 1);
        chk("tp_resume_pc_off", pc_inc, 0);

        // 17 NOPs wrap the 4-bit counter to 1
        do_reset();
        repeat (17) run_instr(4'b1100, 1'b0, 1'b0, 1'b0);
        chk("tp_cnt4_wrap", b_retired, 1);
        chk("tp_cnt16_17", retired, 17);

        // Reset during WB aborts and clears flags
        cycle(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("tp_pre_rst_reg_en", reg_en, 1);
        rst_n = 1'b0;
        #1;
        chk("tp_rst_reg_en", reg_en, 0);
        chk("tp_rst_retired", retired, 0);
        chk("tp_rst_ready", instr_ready, 1);
        do_reset();
        cycle(1'b1, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("tp_rst_flags_jz", jmp_sel, 0);
        cycle(1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0);

        // Randomized run; opcode held until accepted
        do_reset();
        pend_v = 1'b0;
        pend_op = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if (!pend_v) begin
                pend_v  = ($urandom_range(0, 2) != 0);
                pend_op = 4'($urandom_range(0, 15));
            end
            acc = (sched.size() == 0) && !m_halt && pend_v;
            cycle(pend_v, pend_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            if (acc) pend_v = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
